// File: rtl/alu_ctrl_mdu_if.sv
// alu_ctrl_mdu_if: processor-side bundle for the ALU control decoder and multiply/divide unit.
interface alu_ctrl_mdu_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic instr_valid;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [CTRL_W-1:0] alu_control;
    logic md_busy, stall, md_done;
    logic [DATA_W-1:0] md_rdata, hi, lo;
    modport master (
        output alu_op, funct, instr_valid, rs_val, rt_val,
        input alu_control, md_busy, stall, md_done, md_rdata, hi, lo
    );
    modport slave (
        input alu_op, funct, instr_valid, rs_val, rt_val,
        output alu_control, md_busy, stall, md_done, md_rdata, hi, lo
    );
endinterface

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU control decode plus iterative multiply/divide unit with HI/LO registers.
// Define MDU_EARLY_TERM_EN to let MUL finish once the remaining multiplier bits are all zero.
module alu_ctrl_mdu #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input logic clk,
    input logic reset,
    alu_ctrl_mdu_if.slave bus
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_d;
    logic [2*DATA_W-1:0] acc, mcand, fix_res;
    logic [DATA_W-1:0] mplier, hi, lo, a_mag, b_mag, rem, quo;
    logic [DATA_W:0] div_diff;
    logic [CW-1:0] cnt;
    logic [CTRL_W-1:0] ctrl;
    logic op_mul, s_lo, s_hi, md_sel, is_mult, is_div, is_mf, is_mt;
    logic op_sgn, a_neg, b_neg, dz, cnt_last, mul_last, busy, done;
    assign md_sel = bus.instr_valid && bus.alu_op == 2'b10;
    assign is_mult = md_sel && bus.funct[5:1] == 5'b01100;
    assign is_div = md_sel && bus.funct[5:1] == 5'b01101;
    assign is_mf = md_sel && (bus.funct == 6'b010000 || bus.funct == 6'b010010);
    assign is_mt = md_sel && (bus.funct == 6'b010001 || bus.funct == 6'b010011);
    // funct[0] clear selects the signed variant of MULT/DIV
    assign op_sgn = !bus.funct[0];
    assign a_neg = op_sgn && bus.rs_val[DATA_W-1];
    assign b_neg = op_sgn && bus.rt_val[DATA_W-1];
    assign a_mag = a_neg ? -bus.rs_val : bus.rs_val;
    assign b_mag = b_neg ? -bus.rt_val : bus.rt_val;
    assign dz = bus.rt_val == '0;
    assign rem = acc[2*DATA_W-1:DATA_W];
    assign quo = acc[DATA_W-1:0];
    // restoring step: shift the next dividend bit into the remainder and try the subtract
    assign div_diff = {rem, quo[DATA_W-1]} - {1'b0, mcand[DATA_W-1:0]};
    assign fix_res = op_mul ? (s_lo ? -acc : acc) : {s_hi ? -rem : rem, s_lo ? -quo : quo};
    assign cnt_last = cnt == CW'(DATA_W - 1);
`ifdef MDU_EARLY_TERM_EN
    assign mul_last = cnt_last || mplier[DATA_W-1:1] == '0;
`else
    assign mul_last = cnt_last;
`endif
    always_comb begin
        state_d = state;
        busy = state != IDLE;
        done = state == FIX;
        case (state)
            IDLE: state_d = is_mult ? MUL : is_div ? (dz ? FIX : DIV) : IDLE;
            MUL: state_d = mul_last ? FIX : MUL;
            DIV: state_d = cnt_last ? FIX : DIV;
            FIX: state_d = IDLE;
        endcase
    end
    always_comb begin
        ctrl = 4'b1111;
        case (bus.alu_op)
            2'b00: ctrl = 4'b0010;
            2'b01: ctrl = 4'b0110;
            2'b11: ctrl = 4'b0001;
            default:
                case (bus.funct)
                    6'b100000, 6'b100001: ctrl = 4'b0010;
                    6'b100010, 6'b100011: ctrl = 4'b0110;
                    6'b100100: ctrl = 4'b0000;
                    6'b100101: ctrl = 4'b0001;
                    6'b100110: ctrl = 4'b0011;
                    6'b100111: ctrl = 4'b1100;
                    6'b101010: ctrl = 4'b0111;
                    6'b101011: ctrl = 4'b1000;
                    6'b000000: ctrl = 4'b1001;
                    6'b000010: ctrl = 4'b1010;
                    default: ctrl = 4'b1111;
                endcase
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hi <= '0;
            lo <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            op_mul <= 1'b0;
            s_lo <= 1'b0;
            s_hi <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (is_mult) begin
                        op_mul <= 1'b1;
                        acc <= '0;
                        mcand <= {{DATA_W{1'b0}}, a_mag};
                        mplier <= b_mag;
                        s_lo <= a_neg ^ b_neg;
                    end else if (is_div) begin
                        op_mul <= 1'b0;
                        mcand <= {{DATA_W{1'b0}}, b_mag};
                        acc <= dz ? {bus.rs_val, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, a_mag};
                        s_lo <= !dz && (a_neg ^ b_neg);
                        s_hi <= !dz && a_neg;
                    end else if (is_mt) begin
                        if (bus.funct[1]) lo <= bus.rs_val;
                        else hi <= bus.rs_val;
                    end
                end
                MUL: begin
                    acc <= acc + (mplier[0] ? mcand : '0);
                    mcand <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_diff[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                            : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                    cnt <= cnt + 1'b1;
                end
                FIX: {hi, lo} <= fix_res;
            endcase
        end
    end
    assign bus.alu_control = ctrl;
    assign bus.md_busy = busy;
    assign bus.md_done = done;
    assign bus.stall = busy && (is_mult || is_div || is_mf || is_mt);
    assign bus.md_rdata = is_mf ? (bus.funct[1] ? lo : hi) : '0;
    assign bus.hi = hi;
    assign bus.lo = lo;
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: directed and random checks of alu_ctrl_mdu against a behavioural model.
module tb_alu_ctrl_mdu;
    localparam int W = 32;
`ifdef MDU_EARLY_TERM_EN
    localparam int LAT_M3 = 3, LAT_M1 = 2;
`else
    localparam int LAT_M3 = 33, LAT_M1 = 33;
`endif
    logic clk = 0, reset = 1;
    int total = 0, bad = 0;
    bit started = 0;
    logic [W-1:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int left = 0;
    int nb, nd;
    alu_ctrl_mdu_if #(.DATA_W(W), .CTRL_W(4)) bus ();
    alu_ctrl_mdu #(.DATA_W(W), .CTRL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [3:0] exp_ctrl(logic [1:0] op, logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0011;
            6'h27: return 4'b1100;
            6'h2a: return 4'b0111;
            6'h2b: return 4'b1000;
            6'h00: return 4'b1001;
            6'h02: return 4'b1010;
            default: return 4'b1111;
        endcase
    endfunction

    // busy cycles of a multiply: MUL iterations plus the FIX cycle
    function automatic int mul_busy(logic [W-1:0] m);
`ifdef MDU_EARLY_TERM_EN
        int n = 1;
        for (int i = 1; i < W; i++) if ((m >> i) != 0) n = i + 1;
        return n + 1;
`else
        return (m == m) ? W + 1 : W + 1;
`endif
    endfunction

    task automatic launch(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic [W-1:0] mb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mb = b[W-1] ? -b : b;
        if (f == 6'h18) begin
            p = sa * sb;
            left = mul_busy(mb);
        end else if (f == 6'h19) begin
            p = {32'b0, a} * {32'b0, b};
            left = mul_busy(b);
        end else if (b == 0) begin
            p = {a, 32'hffffffff};
            left = 1;
        end else begin
            if (f == 6'h1a) p = {32'(sa % sb), 32'(sa / sb)};
            else p = {a % b, a / b};
            left = W + 1;
        end
        p_hi = p[63:32];
        p_lo = p[31:0];
    endtask

    always @(posedge clk) begin
        logic [5:0] f;
        logic mdv;
        f = bus.funct;
        mdv = bus.instr_valid && bus.alu_op == 2'b10;
        if (reset) begin
            m_hi = 0;
            m_lo = 0;
            left = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (mdv && f >= 6'h18 && f <= 6'h1b) launch(f, bus.rs_val, bus.rt_val);
        else if (mdv && f == 6'h11) m_hi = bus.rs_val;
        else if (mdv && f == 6'h13) m_lo = bus.rs_val;
    end

    always @(negedge clk) begin
        logic mdv, mdop;
        logic [W-1:0] rd;
        if (started) begin
            mdv = bus.instr_valid && bus.alu_op == 2'b10;
            mdop = mdv && ((bus.funct >= 6'h18 && bus.funct <= 6'h1b) || (bus.funct >= 6'h10 && bus.funct <= 6'h13));
            rd = (mdv && bus.funct == 6'h10) ? m_hi : (mdv && bus.funct == 6'h12) ? m_lo : '0;
            chk("alu_control", bus.alu_control, exp_ctrl(bus.alu_op, bus.funct));
            chk("md_busy", bus.md_busy, left > 0);
            chk("md_done", bus.md_done, left == 1);
            chk("stall", bus.stall, left > 0 && mdop);
            chk("md_rdata", bus.md_rdata, rd);
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [1:0] op, logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b);
        bus.instr_valid = v;
        bus.alu_op = op;
        bus.funct = f;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    task automatic wait_idle(output int n, output int d);
        n = 0;
        d = 0;
        while (bus.md_busy && n < 200) begin
            n++;
            d += int'(bus.md_done);
            step();
        end
        chk("busy_bound", bus.md_busy, 0);
    endtask

    task automatic run_md(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b, output int n, output int d);
        drive(1, 2'b10, f, a, b);
        step();
        drive(0, 2'b00, 6'h00, 0, 0);
        wait_idle(n, d);
    endtask

    function automatic logic [W-1:0] rval();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return '1;
            3: return 32'h80000000;
            4: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_instr();
        logic [5:0] f;
        logic [1:0] op;
        op = $urandom_range(0, 1) ? 2'b10 : 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) f = {2'b01, 1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3))};
        else f = 6'($urandom_range(0, 63));
        drive($urandom_range(0, 7) != 0, op, f, rval(), rval());
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 2'b00, 6'h00, 0, 0);
        reset = 1;
        step();
        started = 1;
        step();
        reset = 0;
        chk("rst_busy", bus.md_busy, 0);
        chk("rst_done", bus.md_done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        for (int op = 0; op < 4; op++)
            for (int f = 0; f < 64; f++) begin
                drive(0, 2'(op), 6'(f), 0, 0);
                #1;
                chk("decode", bus.alu_control, exp_ctrl(2'(op), 6'(f)));
                step();
            end
        chk("pin_and", exp_ctrl(2'b10, bus.funct ^ 6'h1b), 4'b0000);
        run_md(6'h18, 32'hfffffffe, 3, nb, nd);
        chk("mult_busy", nb, LAT_M3);
        chk("mult_done", nd, 1);
        chk("mult_hi", bus.hi, 32'hffffffff);
        chk("mult_lo", bus.lo, 32'hfffffffa);
        run_md(6'h19, 32'hfffffffe, 3, nb, nd);
        chk("multu_hi", bus.hi, 32'h00000002);
        chk("multu_lo", bus.lo, 32'hfffffffa);
        run_md(6'h1a, 32'hfffffff9, 2, nb, nd);
        chk("div_busy", nb, 33);
        chk("div_lo", bus.lo, 32'hfffffffd);
        chk("div_hi", bus.hi, 32'hffffffff);
        run_md(6'h1b, 7, 0, nb, nd);
        chk("dz_busy", nb, 1);
        chk("dz_done", nd, 1);
        chk("dz_hi", bus.hi, 7);
        chk("dz_lo", bus.lo, 32'hffffffff);
        run_md(6'h1a, 32'h80000000, 32'hffffffff, nb, nd);
        chk("ovf_lo", bus.lo, 32'h80000000);
        chk("ovf_hi", bus.hi, 0);
        drive(1, 2'b10, 6'h18, 5, 32'h40000007);
        step();
        drive(0, 2'b00, 6'h00, 0, 0);
        repeat (4) step();
        drive(1, 2'b10, 6'h12, 0, 0);
        #1;
        chk("mflo_stall", bus.stall, 1);
        wait_idle(nb, nd);
        chk("mflo_rdata", bus.md_rdata, 32'h40000023);
        chk("mflo_nostall", bus.stall, 0);
        drive(1, 2'b10, 6'h19, 32'h12345678, 32'h80000001);
        step();
        drive(1, 2'b10, 6'h20, 1, 2);
        #1;
        chk("add_busy", bus.md_busy, 1);
        chk("add_stall", bus.stall, 0);
        chk("add_ctrl", bus.alu_control, 4'b0010);
        wait_idle(nb, nd);
        drive(1, 2'b10, 6'h1b, 100, 3);
        step();
        drive(0, 2'b00, 6'h00, 0, 0);
        repeat (10) step();
        reset = 1;
        step();
        reset = 0;
        chk("rdiv_busy", bus.md_busy, 0);
        chk("rdiv_done", bus.md_done, 0);
        chk("rdiv_hi", bus.hi, 0);
        chk("rdiv_lo", bus.lo, 0);
        step();
        chk("rdiv_nodone", bus.md_done, 0);
        drive(1, 2'b10, 6'h11, 32'h1234, 0);
        step();
        drive(1, 2'b10, 6'h10, 0, 0);
        #1;
        chk("mthi_busy", bus.md_busy, 0);
        chk("mfhi_rdata", bus.md_rdata, 32'h1234);
        step();
        run_md(6'h19, 32'hdeadbeef, 1, nb, nd);
        chk("m1_busy", nb, LAT_M1);
        chk("m1_hi", bus.hi, 0);
        chk("m1_lo", bus.lo, 32'hdeadbeef);
        for (int i = 0; i < 1500; i++) begin
            if (!bus.stall) rand_instr();
            reset = $urandom_range(0, 299) == 0;
            step();
        end
        reset = 0;
        drive(0, 2'b00, 6'h00, 0, 0);
        wait_idle(nb, nd);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes alu_op/funct into a 4-bit ALU control code with an extended operation set.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers, a busy/stall handshake to the processor control path, and MTHI/MTLO/MFHI/MFLO support.
- Sits between the main control unit, the register file read ports and the ALU.

Parameters:
- DATA_W, 32, operand/HI/LO width; even, ≥ 8.
- CTRL_W, 4, ALU control code width; fixed at 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_op  in  2  ALU operation class from main control.
- funct  in  6  instruction funct field.
- instr_valid  in  1  a valid instruction is presented this cycle.
- rs_val  in  DATA_W  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  DATA_W  operand B (divisor / multiplier).
- alu_control  out  CTRL_W  ALU operation code (combinational).
- md_busy  out  1  MDU operation in progress.
- stall  out  1  hold the current instruction (combinational).
- md_done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- md_rdata  out  DATA_W  HI on MFHI, LO on MFLO, else 0 (combinational).
- hi, lo  out  DATA_W each  architectural HI/LO registers.

Behaviour:
- alu_control decode:
  - alu_op 00: 0010 (add).
  - alu_op 01: 0110 (sub).
  - alu_op 11: 0001 (or).
  - alu_op 10, by funct: 100000/100001 → 0010; 100010/100011 → 0110; 100100 → 0000; 100101 → 0001; 100110 → 0011; 100111 → 1100; 101010 → 0111 (slt); 101011 → 1000 (sltu); 000000 → 1001 (sll); 000010 → 1010 (srl).
  - Any other funct → 1111. Never X.
- MD ops are decoded only when alu_op=10 && instr_valid:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL/DIV on an accepted MULT*/DIV*. Operands are latched as magnitudes for signed ops; result signs are recorded; iteration counter is cleared.
  - MUL: shift-add, one multiplier bit per cycle, DATA_W cycles, then → FIX.
  - DIV: restoring division, one quotient bit per cycle, DATA_W cycles, then → FIX.
  - DIV/DIVU with rt_val=0: IDLE → FIX directly.
  - FIX: apply signs (product negated if signs differ; quotient sign = sA^sB; remainder sign = sA). Write {hi,lo} on the FIX edge, pulse md_done, → IDLE.
- Latency: acceptance at edge k. md_busy is high from k+1 until the FIX edge k+DATA_W+1, so 33 busy cycles at DATA_W=32. md_done is high during the FIX cycle.
- Divide by zero: hi=rs_val, lo=all ones, busy for exactly 1 cycle.
- DIV of most-negative by -1: lo=100…0, hi=0.
- MTHI/MTLO in IDLE: write rs_val to hi/lo at the next edge, with no busy.
- stall = md_busy && instr_valid && alu_op=10 && funct is any MD op. Non-MD instructions never stall.
- MD ops presented while busy are not accepted. The processor re-presents them, and they are accepted in the cycle after md_busy falls.
- An MD op in the FIX cycle is stalled, since busy is still high then.
- MFHI/MFLO during busy: stalled, and md_rdata is don't-care-free (shows the current hi/lo).
- Reset, including mid-operation: state IDLE, hi=lo=0, md_busy=0, md_done=0. The in-flight operation is discarded.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: the MUL state exits to FIX as soon as the remaining unshifted multiplier bits are all zero, checked after each iteration (minimum 1 MUL cycle). Example: MULTU with rt_val=1 is busy for 2 cycles. DIV latency is unchanged.
- Undefined: fixed DATA_W-cycle MUL latency, and the early-exit logic is absent.

Test Plan:
- Decode sweep: all alu_op values and all 64 funct values → exact alu_control per the table; unlisted codes give 1111, never X.
- MULT rs=0xFFFFFFFE (-2), rt=3:
  - md_busy for exactly 33 cycles.
  - md_done in the FIX cycle.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU of the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → hi=7, lo=0xFFFFFFFF after 1 busy cycle.
- MFLO issued 5 cycles after a MULT → stall high until md_busy falls, then md_rdata=new lo. An ADD issued during busy → stall low, alu_control=0010.
- Reset pulsed mid-DIV → next cycle md_busy=0, hi=lo=0, no md_done. MTHI rs=0x1234 then MFHI → md_rdata=0x1234.
- With MDU_EARLY_TERM_EN: MULTU rt=1 → busy 2 cycles, correct product. Without it: 33 cycles, same product.
